// File: rtl/register_unit.sv
// register_unit: RV32I 32x32 register file, x0 hardwired to zero, 2 combinational reads, 1 sync write.
// Optional macro REG_UNIT_WR_BYPASS_EN forwards same-cycle write data to matching read ports.
module register_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] DataWr,
    input  logic            RUWr,
    output logic [XLEN-1:0] RURs1,
    output logic [XLEN-1:0] RURs2
);
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];
    logic            wr_en;
    logic [XLEN-1:0] rd1_raw;
    logic [XLEN-1:0] rd2_raw;
    assign wr_en = RUWr && (rd != 5'd0);
    always_comb begin
        for (int i = 1; i < NREGS; i++) begin
            regs_d[i] = !rst_n ? '0 : (wr_en && rd == 5'(i)) ? DataWr : regs_q[i];
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 1; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end
    assign rd1_raw = (rs1 == 5'd0) ? '0 : regs_q[rs1];
    assign rd2_raw = (rs2 == 5'd0) ? '0 : regs_q[rs2];
`ifdef REG_UNIT_WR_BYPASS_EN
    // rd != 0 inside wr_en keeps index 0 reading zero even when forwarding
    assign RURs1 = (rst_n && wr_en && rs1 == rd) ? DataWr : rd1_raw;
    assign RURs2 = (rst_n && wr_en && rs2 == rd) ? DataWr : rd2_raw;
`else
    assign RURs1 = rd1_raw;
    assign RURs2 = rd2_raw;
`endif
endmodule

// File: tb/tb_register_unit.sv
// tb_register_unit: directed self-checking bench for register_unit.
// Expectations follow REG_UNIT_WR_BYPASS_EN when the bench is built with it.
module tb_register_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] DataWr;
    logic        RUWr;
    logic [31:0] RURs1, RURs2;
    int          n_cmp = 0;
    int          n_err = 0;

    register_unit dut (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rd(rd),
        .DataWr(DataWr), .RUWr(RUWr), .RURs1(RURs1), .RURs2(RURs2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] same_cycle_exp;
`ifdef REG_UNIT_WR_BYPASS_EN
        same_cycle_exp = 32'hA5A5_A5A5;
`else
        same_cycle_exp = 32'h1111_1111;
`endif
        rst_n = 1'b0; RUWr = 1'b0; rd = 5'd0; DataWr = 32'h0; rs1 = 5'd0; rs2 = 5'd0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            chk($sformatf("reset_rs1_x%0d", i), RURs1, 32'h0);
            chk($sformatf("reset_rs2_x%0d", 31 - i), RURs2, 32'h0);
        end

        rs1 = 5'd1; rs2 = 5'd2;
        RUWr = 1'b1; rd = 5'd1; DataWr = 32'h0000_0008;
        step();
        chk("wr_x1_visible", RURs1, 32'h0000_0008);
        rd = 5'd2; DataWr = 32'h0000_000A;
        step();
        chk("wr2_rs1_x1", RURs1, 32'h0000_0008);
        chk("wr2_rs2_x2", RURs2, 32'h0000_000A);
        rd = 5'd3; DataWr = 32'hFFFF_FFFE;
        step();
        rs1 = 5'd3;
        #1;
        chk("wr3_rs1_x3", RURs1, 32'hFFFF_FFFE);
        chk("wr3_rs2_x2", RURs2, 32'h0000_000A);

        RUWr = 1'b0; rd = 5'd1; DataWr = 32'hFFFF_FFFE;
        step();
        rs1 = 5'd1;
        #1;
        chk("wr_disabled_x1", RURs1, 32'h0000_0008);

        RUWr = 1'b1; rd = 5'd0; DataWr = 32'h0000_0001;
        step();
        step();
        rs1 = 5'd1; rs2 = 5'd0;
        #1;
        chk("x0_wr_rs1_x1", RURs1, 32'h0000_0008);
        chk("x0_wr_rs2_x0", RURs2, 32'h0);
        rs1 = 5'd0; DataWr = 32'hFFFF_FFFF;
        #1;
        chk("x0_no_bypass", RURs1, 32'h0);

        RUWr = 1'b0; rs1 = 5'd2; rs2 = 5'd2;
        #1;
        chk("same_reg_p1", RURs1, 32'h0000_000A);
        chk("same_reg_p2", RURs2, 32'h0000_000A);

        RUWr = 1'b1; rd = 5'd31; DataWr = 32'hDEAD_BEEF;
        step();
        RUWr = 1'b0; rs1 = 5'd31; rs2 = 5'd30;
        #1;
        chk("wr_x31", RURs1, 32'hDEAD_BEEF);
        chk("x30_untouched", RURs2, 32'h0);

        RUWr = 1'b1; rd = 5'd4; DataWr = 32'h1111_1111;
        step();
        rs1 = 5'd4; rs2 = 5'd4; DataWr = 32'hA5A5_A5A5;
        #1;
        chk("same_cycle_pre_p1", RURs1, same_cycle_exp);
        chk("same_cycle_pre_p2", RURs2, same_cycle_exp);
        step();
        chk("same_cycle_post_p1", RURs1, 32'hA5A5_A5A5);

        rst_n = 1'b0; RUWr = 1'b1; rd = 5'd5; DataWr = 32'h1234_5678; rs1 = 5'd4; rs2 = 5'd5;
        #1;
        chk("rst_pending_x4", RURs1, 32'hA5A5_A5A5);
        chk("rst_pending_no_fwd_x5", RURs2, 32'h0);
        step();
        rst_n = 1'b1; RUWr = 1'b0;
        #1;
        chk("rst_prio_x5", RURs2, 32'h0);
        chk("rst_clr_x4", RURs1, 32'h0);
        rs1 = 5'd1; rs2 = 5'd2;
        #1;
        chk("rst_clr_x1", RURs1, 32'h0);
        chk("rst_clr_x2", RURs2, 32'h0);
        rs1 = 5'd3; rs2 = 5'd31;
        #1;
        chk("rst_clr_x3", RURs1, 32'h0);
        chk("rst_clr_x31", RURs2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
